// File: rtl/alu_result_log.sv
// Result FIFO between float_alu and hex_display; the head is shown one 16-bit half at a time.
// A push or pop is visible on the outputs the cycle after its edge; in_ready drops when full or while clear is high.
module alu_result_log #(
    parameter int DEPTH  = 8,
    parameter int RES_W  = 32,
    parameter int FLAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [RES_W-1:0]         in_result,
    input  logic [FLAG_W-1:0]        in_flags,
    output logic                     in_ready,
    input  logic                     pop,
    input  logic                     step,
    input  logic                     clear,
    output logic [15:0]              disp_data,
    output logic [FLAG_W-1:0]        disp_flags,
    output logic                     disp_half,
    output logic                     disp_enable,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [RES_W-1:0]  result;
    } entry_t;

    typedef enum logic [1:0] {
        V_EMPTY = 2'd0,
        V_LO    = 2'd1,
        V_HI    = 2'd2
    } view_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    view_t           view_q;
    view_t           view_d;
    logic            push;
    logic            do_pop;
    entry_t          head;

    // clear is the only input allowed to reach an output combinationally
    assign in_ready = (cnt_q != FULL) && !clear;
    assign push     = in_valid && in_ready;
    assign do_pop   = pop && (cnt_q != '0) && !clear;
    assign head     = mem[rd_ptr];
    assign count    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // storage is deliberately left out of reset; the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{flags: in_flags, result: in_result};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            view_q <= V_EMPTY;
        end else begin
            view_q <= view_d;
        end
    end

    always_comb begin
        view_d = view_q;
        if (clear) begin
            view_d = V_EMPTY;
        end else if (do_pop) begin
            // any pop restarts on the low half of whatever becomes head
            view_d = (cnt_d != '0) ? V_LO : V_EMPTY;
        end else begin
            case (view_q)
                V_EMPTY: if (push) view_d = V_LO;
                V_LO:    if (step) view_d = V_HI;
                V_HI:    if (step) view_d = V_LO;
                default: view_d = V_EMPTY;
            endcase
        end
    end

    always_comb begin
        disp_data   = '0;
        disp_flags  = '0;
        disp_half   = 1'b0;
        disp_enable = 1'b0;
        case (view_q)
            V_LO: begin
                disp_data   = head.result[15:0];
                disp_flags  = head.flags;
                disp_enable = 1'b1;
            end
            V_HI: begin
                disp_data   = head.result[31:16];
                disp_flags  = head.flags;
                disp_half   = 1'b1;
                disp_enable = 1'b1;
            end
            default: begin
                disp_data   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_log.sv
// Directed vector table for the documented scenarios, then random traffic against a queue model.
module tb_alu_result_log;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic        in_ready;
    logic        pop;
    logic        step;
    logic        clear;
    logic [15:0] disp_data;
    logic [4:0]  disp_flags;
    logic        disp_half;
    logic        disp_enable;
    logic [3:0]  count;

    int n_vec;
    int n_err;

    alu_result_log #(.DEPTH(8), .RES_W(32), .FLAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .in_ready    (in_ready),
        .pop         (pop),
        .step        (step),
        .clear       (clear),
        .disp_data   (disp_data),
        .disp_flags  (disp_flags),
        .disp_half   (disp_half),
        .disp_enable (disp_enable),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        pop;
        logic        step;
        logic        clr;
        logic        ck_rdy;
        logic        exp_rdy;
        logic [3:0]  exp_cnt;
        logic [15:0] exp_dat;
        logic [4:0]  exp_flg;
        logic        exp_half;
        logic        exp_en;
    } vec_t;

    vec_t tbl[$];
    logic [36:0] mq[$];
    logic        mhalf;

    function automatic vec_t mk(
        input logic rs, input logic vl, input logic [31:0] rv, input logic [4:0] fl,
        input logic pp, input logic st, input logic cl,
        input logic ckr, input logic er, input logic [3:0] ec,
        input logic [15:0] ed, input logic [4:0] ef, input logic eh, input logic ee);
        vec_t v;
        v.rst = rs; v.vld = vl; v.res = rv; v.flg = fl;
        v.pop = pp; v.step = st; v.clr = cl;
        v.ck_rdy = ckr; v.exp_rdy = er; v.exp_cnt = ec;
        v.exp_dat = ed; v.exp_flg = ef; v.exp_half = eh; v.exp_en = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst       = v.rst;
        in_valid  = v.vld;
        in_result = v.res;
        in_flags  = v.flg;
        pop       = v.pop;
        step      = v.step;
        clear     = v.clr;
        #1;
        if (v.ck_rdy) chk("in_ready", {31'd0, in_ready}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        chk("count",       {28'd0, count},       {28'd0, v.exp_cnt});
        chk("disp_data",   {16'd0, disp_data},   {16'd0, v.exp_dat});
        chk("disp_flags",  {27'd0, disp_flags},  {27'd0, v.exp_flg});
        chk("disp_half",   {31'd0, disp_half},   {31'd0, v.exp_half});
        chk("disp_enable", {31'd0, disp_enable}, {31'd0, v.exp_en});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0;
        pop = 1'b0; step = 1'b0; clear = 1'b0;

        // reset, single entry browsing
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3FC00000, 5'd1, 0, 0, 0, 1, 1, 1, 16'h0000, 5'd1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h3FC0, 5'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0000, 5'd1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0));
        // fill to full, back-pressure, pop through the wrap
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 32'(k), 5'(k), 0, 0, 0, 1, 1, 4'(k), 16'h0001, 5'd1, 0, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 32'd9, 5'd9, 0, 0, 0, 1, 0, 4'd8, 16'h0001, 5'd1, 0, 1));
        tbl.push_back(mk(0, 1, 32'd9, 5'd9, 1, 0, 0, 1, 0, 4'd7, 16'h0002, 5'd2, 0, 1));
        tbl.push_back(mk(0, 1, 32'd9, 5'd9, 0, 0, 0, 1, 1, 4'd8, 16'h0002, 5'd2, 0, 1));
        for (int i = 1; i <= 8; i++) begin
            if (i < 8)
                tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, (i != 1), 4'(8 - i),
                                 16'(i + 2), 5'(i + 2), 0, 1));
            else
                tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 4'd0, 16'h0000, 5'd0, 0, 0));
        end
        // simultaneous push and pop at count 1, starting from the high half
        tbl.push_back(mk(0, 1, 32'hAAAA5555, 5'd3, 0, 0, 0, 1, 1, 4'd1, 16'h5555, 5'd3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 4'd1, 16'hAAAA, 5'd3, 1, 1));
        tbl.push_back(mk(0, 1, 32'h12345678, 5'd4, 1, 0, 0, 1, 1, 4'd1, 16'h5678, 5'd4, 0, 1));
        // clear at count 5 in V_HI with a pending push
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 32'h100 + 32'(k), 5'd0, 0, 0, 0, 1, 1, 4'(k + 2), 16'h5678, 5'd4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 4'd5, 16'h1234, 5'd4, 1, 1));
        tbl.push_back(mk(0, 1, 32'hDEADBEEF, 5'd31, 0, 0, 1, 1, 0, 4'd0, 16'h0000, 5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'd0, 16'h0000, 5'd0, 0, 0));
        // pop and step on empty are ignored
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 4'd0, 16'h0000, 5'd0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000BEEF, 5'd7, 0, 0, 0, 1, 1, 4'd1, 16'hBEEF, 5'd7, 0, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // random traffic, including mid-run resets and clears
        mq.delete();
        mhalf = 1'b0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_vld, r_pop, r_step, r_clr, e_rdy, e_en, e_half;
            logic [31:0] r_res;
            logic [4:0]  r_flg, e_flg;
            logic [15:0] e_dat;
            r_rst  = ($urandom_range(99) < 2);
            r_vld  = ($urandom_range(99) < 60);
            r_pop  = ($urandom_range(99) < 30);
            r_step = ($urandom_range(99) < 30);
            r_clr  = ($urandom_range(99) < 3);
            r_res  = $urandom;
            r_flg  = 5'($urandom_range(31));
            e_rdy  = (mq.size() < 8) && !r_clr;
            if (r_rst || r_clr) begin
                mq.delete();
                mhalf = 1'b0;
            end else begin
                if (r_pop && mq.size() > 0) begin
                    void'(mq.pop_front());
                    mhalf = 1'b0;
                end else if (r_step && mq.size() > 0) begin
                    mhalf = ~mhalf;
                end
                if (r_vld && e_rdy) begin
                    if (mq.size() == 0) mhalf = 1'b0;
                    mq.push_back({r_flg, r_res});
                end
            end
            if (mq.size() > 0) begin
                e_en   = 1'b1;
                e_half = mhalf;
                e_flg  = mq[0][36:32];
                e_dat  = mhalf ? mq[0][31:16] : mq[0][15:0];
            end else begin
                e_en = 1'b0; e_half = 1'b0; e_flg = '0; e_dat = '0;
            end
            apply(mk(r_rst, r_vld, r_res, r_flg, r_pop, r_step, r_clr, 1, e_rdy,
                     4'(mq.size()), e_dat, e_flg, e_half, e_en));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
